image_draw: RTL and testbench
=============================

IMAGE_DRAW -- requirements
Module: image_draw

Interface
REQ-001 Parameter IMG_W, default 48, sprite width in pixels.
REQ-002 Parameter IMG_H, default 64, sprite height in pixels.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 hcount_in, vcount_in  input  11 each  pixel coordinates from the timing/background stage.
REQ-006 hsync_in, vsync_in, hblnk_in, vblnk_in  input  1 each  sync and blanking flags.
REQ-007 rgb_in  input  12  background colour {R,G,B} 4 bits each.
REQ-008 xpos, ypos  input  12 each  requested sprite top-left corner; asynchronous to frame.
REQ-009 pixel_addr  output  12  image ROM address {y_rel[5:0], x_rel[5:0]}.
REQ-010 rgb_pixel  input  12  image ROM data; valid one clk after pixel_addr.
REQ-011 hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out  output  same widths as inputs  delayed and composited stream.

Function
REQ-012 Block SHALL present a fixed latency of 3 clk from any input to the corresponding output for every timing and colour signal.
REQ-013 Stage 1 SHALL register pixel_addr, the inside flag, and all timing/rgb_in inputs.
REQ-014 Stage 2 SHALL delay stage-1 contents by one clk, aligned with rgb_pixel from the ROM.
REQ-015 Stage 3 SHALL register the outputs: rgb_out = rgb_pixel when inside, else rgb_in; forced to 12'h000 when hblnk or vblnk is set.
REQ-016 x_rel = hcount_in − xpos_s and y_rel = vcount_in − ypos_s SHALL be computed in 13-bit signed arithmetic; no wrap-around.
REQ-017 inside SHALL be 1 only when 0 ≤ x_rel < IMG_W and 0 ≤ y_rel < IMG_H and neither blank flag is set.
REQ-018 pixel_addr SHALL be 12'h000 when not inside.
REQ-019 Shadow registers xpos_s/ypos_s SHALL load xpos/ypos only on the clk where vblnk_in rises (0→1), so the sprite moves only between frames.
REQ-020 Sprite partially beyond the right or bottom edge SHALL be clipped; it SHALL never reappear on the left or top.
REQ-021 xpos or ypos at 12'hFFF SHALL produce no sprite pixels on screen.

Reset
REQ-022 rst SHALL clear all pipeline registers, all outputs, and xpos_s/ypos_s to 0.
REQ-023 Reset asserted mid-frame SHALL zero outputs on the next clk.
REQ-024 After reset release, the sprite SHALL draw at (0,0) until the first vblnk_in rising edge.
REQ-025 The vblnk edge detector SHALL reset to 1, so a frame starting in blank does not produce a false edge.

Configuration
REQ-026 Macro IMAGE_DRAW_TRANSPARENCY_EN defined: a ROM pixel equal to key colour 12'hF0F SHALL be treated as outside, so rgb_in passes through.
REQ-027 Macro IMAGE_DRAW_TRANSPARENCY_EN undefined: every inside pixel, including 12'hF0F, SHALL show rgb_pixel; latency remains unchanged.

Structure
REQ-028 The shared package SHALL hold IMG_W/IMG_H defaults, latency constant (3), key colour 12'hF0F, and the coordinate widths (11, 12).
REQ-029 One sub-module, signal_delay (parameters WIDTH, DEPTH, synchronous reset), SHALL implement the timing-signal pipeline.
REQ-030 The ROM is external to this block; pixel_addr and rgb_pixel connect to it at the top level.

Verification
REQ-031 xpos=100, ypos=50, hcount_in=100, vcount_in=50 → pixel_addr=12'h000 and inside=1 one clk later; rgb_out equals ROM[0] three clk after input.
REQ-032 hcount_in=147, vcount_in=113, same position → pixel_addr={6'd63,6'd47}=12'hFEF; at hcount_in=148, rgb_out=rgb_in.
REQ-033 xpos changes 100→200 mid-frame → sprite stays at x=100 until the vblnk_in rise; next frame it is drawn at x=200.
REQ-034 xpos=1000 on a 1024-wide frame → only 24 columns drawn; no pixels appear at hcount 0..23.
REQ-035 IMAGE_DRAW_TRANSPARENCY_EN defined, ROM word 12'hF0F, rgb_in=12'h0A0 → rgb_out=12'h0A0; undefined → rgb_out=12'hF0F.
REQ-036 rst pulsed mid-line → all outputs 0 next clk; after release, hsync_out follows hsync_in with exactly 3-clk delay.

Source files
------------

// File: rtl/image_draw_pkg.sv
// image_draw_pkg
// Shared constants for the sprite compositor: default sprite size, pipeline
// latency, transparency key colour and the coordinate/colour widths.
// A small helper identifies the transparency key colour.
package image_draw_pkg;
   localparam int IMG_W_DEF = 48;
   localparam int IMG_H_DEF = 64;
   localparam int LATENCY   = 3;
   localparam int CNT_W     = 11;   // hcount/vcount width
   localparam int POS_W     = 12;   // xpos/ypos width
   localparam int RGB_W     = 12;
   localparam int ADDR_W    = 12;
   localparam int REL_W     = 13;   // signed relative coordinate width
   localparam logic [RGB_W-1:0] KEY_COLOUR = 12'hF0F;

   function automatic logic is_key(input logic [RGB_W-1:0] c);
      return c == KEY_COLOUR;
   endfunction
endpackage

// File: rtl/signal_delay.sv
// signal_delay
// Generic shift-register delay line with synchronous active-high reset.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset, clears every stage
//   din  - WIDTH-bit input word
//   dout - din delayed by DEPTH clocks (DEPTH >= 1)
module signal_delay #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);
   logic [WIDTH-1:0] pipe [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= din;
         for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign dout = pipe[DEPTH-1];
endmodule

// File: rtl/image_draw.sv
// image_draw
// Composites a sprite read from an external image ROM over a background
// pixel stream. Fixed latency of 3 clocks on every timing and colour signal.
// The sprite position is sampled into shadow registers only on a rising edge
// of vblnk_in, so the sprite moves between frames only.
// Optional feature (macro IMAGE_DRAW_TRANSPARENCY_EN): a ROM word equal to the
// key colour 12'hF0F is treated as outside the sprite.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   hcount_in, vcount_in     - pixel coordinates (11 bit)
//   hsync_in, vsync_in       - sync flags
//   hblnk_in, vblnk_in       - blanking flags
//   rgb_in                   - background colour {R,G,B}
//   xpos, ypos               - requested sprite top-left corner (12 bit)
//   pixel_addr               - image ROM address {y_rel[5:0], x_rel[5:0]}
//   rgb_pixel                - image ROM data, one clock after pixel_addr
//   *_out                    - inputs delayed by 3 clocks, rgb_out composited
module image_draw
   import image_draw_pkg::*;
#(
   parameter int IMG_W = IMG_W_DEF,
   parameter int IMG_H = IMG_H_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CNT_W-1:0]  hcount_in,
   input  logic [CNT_W-1:0]  vcount_in,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic              hblnk_in,
   input  logic              vblnk_in,
   input  logic [RGB_W-1:0]  rgb_in,
   input  logic [POS_W-1:0]  xpos,
   input  logic [POS_W-1:0]  ypos,
   output logic [ADDR_W-1:0] pixel_addr,
   input  logic [RGB_W-1:0]  rgb_pixel,
   output logic [CNT_W-1:0]  hcount_out,
   output logic [CNT_W-1:0]  vcount_out,
   output logic              hsync_out,
   output logic              vsync_out,
   output logic              hblnk_out,
   output logic              vblnk_out,
   output logic [RGB_W-1:0]  rgb_out
);
   localparam int TIM_W  = 2*CNT_W + 4 + RGB_W;
   localparam int HALF_A = ADDR_W / 2;
   localparam logic signed [REL_W-1:0] W_S = REL_W'(IMG_W);
   localparam logic signed [REL_W-1:0] H_S = REL_W'(IMG_H);

   logic [POS_W-1:0]        xpos_s, ypos_s;
   logic                    vblnk_prev;
   logic                    vblnk_rise;
   logic signed [REL_W-1:0] x_rel, y_rel;
   logic                    inside_p0;
   logic                    inside_p1, inside_p2;
   logic                    show_p2;
   logic [TIM_W-1:0]        tim_p0, tim_p2;
   logic [CNT_W-1:0]        hcount_p2, vcount_p2;
   logic                    hsync_p2, vsync_p2, hblnk_p2, vblnk_p2;
   logic [RGB_W-1:0]        rgb_p2;

   // Edge detector starts at 1 so a frame that begins in blanking does not
   // look like a fresh vblnk rise.
   assign vblnk_rise = vblnk_in & ~vblnk_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         xpos_s     <= '0;
         ypos_s     <= '0;
         vblnk_prev <= 1'b1;
      end else begin
         vblnk_prev <= vblnk_in;
         if (vblnk_rise) begin
            xpos_s <= xpos;
            ypos_s <= ypos;
         end
      end
   end

   // Zero-extended operands keep the subtraction signed without wrap-around,
   // so a sprite hanging off the right/bottom edge never reappears left/top.
   assign x_rel = $signed({2'b00, hcount_in}) - $signed({1'b0, xpos_s});
   assign y_rel = $signed({2'b00, vcount_in}) - $signed({1'b0, ypos_s});

   assign inside_p0 = !x_rel[REL_W-1] && (x_rel < W_S) &&
                      !y_rel[REL_W-1] && (y_rel < H_S) &&
                      !hblnk_in && !vblnk_in;

   assign tim_p0 = {hcount_in, vcount_in, hsync_in, vsync_in,
                    hblnk_in, vblnk_in, rgb_in};

   // ---- stage 1: ROM address and inside flag ----
   always_ff @(posedge clk) begin
      if (rst) begin
         pixel_addr <= '0;
         inside_p1  <= 1'b0;
      end else begin
         inside_p1  <= inside_p0;
         pixel_addr <= inside_p0 ? {y_rel[HALF_A-1:0], x_rel[HALF_A-1:0]} : '0;
      end
   end

   // ---- stage 2: aligned with rgb_pixel returning from the ROM ----
   always_ff @(posedge clk) begin
      if (rst) inside_p2 <= 1'b0;
      else     inside_p2 <= inside_p1;
   end

   signal_delay #(
      .WIDTH (TIM_W),
      .DEPTH (LATENCY - 1)
   ) u_tim_delay (
      .clk  (clk),
      .rst  (rst),
      .din  (tim_p0),
      .dout (tim_p2)
   );

   assign {hcount_p2, vcount_p2, hsync_p2, vsync_p2,
           hblnk_p2, vblnk_p2, rgb_p2} = tim_p2;

`ifdef IMAGE_DRAW_TRANSPARENCY_EN
   assign show_p2 = inside_p2 && !is_key(rgb_pixel);
`else
   assign show_p2 = inside_p2;
`endif

   // ---- stage 3: composited outputs ----
   always_ff @(posedge clk) begin
      if (rst) begin
         hcount_out <= '0;
         vcount_out <= '0;
         hsync_out  <= 1'b0;
         vsync_out  <= 1'b0;
         hblnk_out  <= 1'b0;
         vblnk_out  <= 1'b0;
         rgb_out    <= '0;
      end else begin
         hcount_out <= hcount_p2;
         vcount_out <= vcount_p2;
         hsync_out  <= hsync_p2;
         vsync_out  <= vsync_p2;
         hblnk_out  <= hblnk_p2;
         vblnk_out  <= vblnk_p2;
         if (hblnk_p2 || vblnk_p2) rgb_out <= '0;
         else if (show_p2)         rgb_out <= rgb_pixel;
         else                      rgb_out <= rgb_p2;
      end
   end
endmodule

// File: tb/tb_image_draw.sv
// tb_image_draw
// Self-checking bench for image_draw. A behavioural ROM answers pixel_addr one
// clock later. The reference model keeps a per-cycle history of expected
// results computed from plain integer arithmetic on the sprite rules and
// compares pixel_addr one clock and all outputs three clocks after each input.
// Honours IMAGE_DRAW_TRANSPARENCY_EN when the bench is built with it.
module tb_image_draw;
   import image_draw_pkg::*;

   localparam int NCYC = 4000;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] hcount_in, vcount_in;
   logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
   logic [11:0] rgb_in, xpos, ypos;
   logic [11:0] pixel_addr;
   logic [11:0] rgb_pixel;
   logic [10:0] hcount_out, vcount_out;
   logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
   logic [11:0] rgb_out;

   always #5 clk = ~clk;

   image_draw dut (
      .clk        (clk),
      .rst        (rst),
      .hcount_in  (hcount_in),
      .vcount_in  (vcount_in),
      .hsync_in   (hsync_in),
      .vsync_in   (vsync_in),
      .hblnk_in   (hblnk_in),
      .vblnk_in   (vblnk_in),
      .rgb_in     (rgb_in),
      .xpos       (xpos),
      .ypos       (ypos),
      .pixel_addr (pixel_addr),
      .rgb_pixel  (rgb_pixel),
      .hcount_out (hcount_out),
      .vcount_out (vcount_out),
      .hsync_out  (hsync_out),
      .vsync_out  (vsync_out),
      .hblnk_out  (hblnk_out),
      .vblnk_out  (vblnk_out),
      .rgb_out    (rgb_out)
   );

   // Synchronous image ROM
   logic [11:0] rom [4096];
   always_ff @(posedge clk) rgb_pixel <= rom[pixel_addr];

   // Reference model state and expectation history
   logic [11:0] m_xs, m_ys;
   bit          m_vprev;
   bit          r_hist [NCYC];
   logic [11:0] e_addr [NCYC];
   logic [25:0] e_tim  [NCYC];
   logic [11:0] e_rgb  [NCYC];

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input int k);
      int xr, yr;
      bit ins, transparent;
      logic [11:0] addr, rp;
      r_hist[k] = rst;
      if (rst) begin
         m_xs = '0; m_ys = '0; m_vprev = 1'b1;
         e_addr[k] = '0; e_tim[k] = '0; e_rgb[k] = '0;
         return;
      end
      xr  = int'(hcount_in) - int'(m_xs);
      yr  = int'(vcount_in) - int'(m_ys);
      ins = (xr >= 0) && (xr < IMG_W_DEF) && (yr >= 0) && (yr < IMG_H_DEF) &&
            !hblnk_in && !vblnk_in;
      addr = ins ? 12'(yr * 64 + xr) : 12'h000;
      rp = rom[addr];
`ifdef IMAGE_DRAW_TRANSPARENCY_EN
      transparent = (rp == 12'hF0F);
`else
      transparent = 1'b0;
`endif
      e_addr[k] = addr;
      e_tim[k]  = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};
      if (hblnk_in || vblnk_in)   e_rgb[k] = 12'h000;
      else if (ins && !transparent) e_rgb[k] = rp;
      else                        e_rgb[k] = rgb_in;
      if (vblnk_in && !m_vprev) begin
         m_xs = xpos;
         m_ys = ypos;
      end
      m_vprev = vblnk_in;
   endtask

   task automatic drive_directed(input int idx);
      hblnk_in = 1'b0;
      case (idx)
         0:  begin xpos = 12'd100; ypos = 12'd50; vblnk_in = 1'b1; end
         1:  begin vblnk_in = 1'b0; hcount_in = 11'd100; vcount_in = 11'd50; end
         2:  begin hcount_in = 11'd147; vcount_in = 11'd113; end
         3:  begin hcount_in = 11'd148; vcount_in = 11'd113; end
         4:  begin hcount_in = 11'd99;  vcount_in = 11'd50; end
         5:  begin hcount_in = 11'd100; vcount_in = 11'd49; end
         6:  begin hcount_in = 11'd147; vcount_in = 11'd114; end
         7:  begin xpos = 12'd200; hcount_in = 11'd100; vcount_in = 11'd60; end
         8:  begin hcount_in = 11'd200; vcount_in = 11'd60; end
         9:  begin vblnk_in = 1'b1; end
         10: begin vblnk_in = 1'b0; hcount_in = 11'd200; vcount_in = 11'd60; end
         11: begin xpos = 12'd1000; ypos = 12'd0; vblnk_in = 1'b1; end
         12: begin vblnk_in = 1'b0; hcount_in = 11'd10; vcount_in = 11'd5; end
         13: begin hcount_in = 11'd1023; vcount_in = 11'd5; end
         14: begin xpos = 12'hFFF; ypos = 12'hFFF; vblnk_in = 1'b1; end
         default: begin vblnk_in = 1'b0; hcount_in = 11'(idx); vcount_in = 11'(idx); end
      endcase
   endtask

   task automatic drive_random();
      int h, v;
      if ($urandom % 30 == 0) begin
         case ($urandom % 5)
            0: begin xpos = 12'($urandom); ypos = 12'($urandom); end
            1: begin xpos = 12'hFFF; ypos = 12'($urandom_range(0, 100)); end
            2: begin xpos = 12'($urandom_range(1990, 2047)); ypos = 12'($urandom_range(1990, 2047)); end
            3: begin xpos = 12'($urandom_range(0, 100)); ypos = 12'($urandom_range(0, 100)); end
            default: begin xpos = 12'($urandom_range(900, 1100)); ypos = 12'hFFF; end
         endcase
      end
      if (vblnk_in) vblnk_in = ($urandom % 4 != 0);
      else          vblnk_in = ($urandom % 50 == 0);
      hblnk_in = ($urandom % 8 == 0);
      if ($urandom % 10 < 7) begin
         h = int'(m_xs) + int'($urandom_range(0, 56)) - 4;
         v = int'(m_ys) + int'($urandom_range(0, 72)) - 4;
      end else begin
         h = int'($urandom_range(0, 2047));
         v = int'($urandom_range(0, 2047));
      end
      hcount_in = 11'(h);
      vcount_in = 11'(v);
   endtask

   initial begin
      logic z;
      for (int i = 0; i < 4096; i++)
         rom[i] = ($urandom % 8 == 0) ? 12'hF0F : 12'($urandom);
      rom[0] = 12'h5A3;
      rst = 1'b1;
      hcount_in = '0; vcount_in = '0;
      hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
      rgb_in = '0; xpos = '0; ypos = '0;
      m_xs = '0; m_ys = '0; m_vprev = 1'b1;

      for (int k = 0; k < NCYC; k++) begin
         @(posedge clk);
         #1;
         if (k >= 1)
            check("pixel_addr", 64'(pixel_addr), r_hist[k-1] ? 64'h0 : 64'(e_addr[k-1]));
         if (k >= 3) begin
            z = r_hist[k-1] || r_hist[k-2] || r_hist[k-3];
            check("timing_out",
                  64'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}),
                  z ? 64'h0 : 64'(e_tim[k-3]));
            check("rgb_out", 64'(rgb_out), z ? 64'h0 : 64'(e_rgb[k-3]));
         end

         // inputs for cycle k
         rst      = (k < 5) || (k == 2000) || (k == 2001);
         rgb_in   = 12'($urandom);
         hsync_in = 1'($urandom);
         vsync_in = 1'($urandom);
         if (k >= 5 && k < 22)  drive_directed(k - 5);
         else if (k >= 22)      drive_random();
         model_step(k);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
